fsqrt_seq: RTL and testbench
============================

# fsqrt_seq

- Sequencer for single-precision `FSQRT.S` that sits between the FPU operand bus and the iterative 24-bit square-root core.
- Accepts one IEEE-754 binary32 operand per transaction and classifies it. Special operands are resolved locally; all other operands are unpacked and issued to the core as significand plus exponent-parity.
- Captures the core's 36-bit root, then rounds per the RISC-V `rm` field, packs the result and returns it with `fflags` over a valid/ready handshake.

## Interface
Parameters:
- `CANON_NAN`, default `32'h7FC0_0000`: result for every NaN-producing case.

Ports:
- `clk` in 1: clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: operand present.
- `in_ready` out 1: block can accept an operand; high only in IDLE.
- `in_operand` in 32: binary32 radicand.
- `in_rm` in 3: rounding mode, already resolved (no DYN).
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out 32: binary32 root.
- `out_fflags` out 5: {NV, DZ, OF, UF, NX}. DZ, OF and UF are always 0.
- `core_start` out 1: one-cycle start pulse to the root core.
- `core_is_exp_odd` out 1: unbiased exponent is odd.
- `core_significand` out 24: {1, fraction}, normalized.
- `core_done` in 1: core result valid this cycle.
- `core_sq_root` in 36: core root. Bit 35 is the leading 1.

## Operation
- **States:** IDLE, START, WAIT, ROUND, OUT.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`, register the operand and `rm`, then classify:
    - Operand is NaN: result `CANON_NAN`; NV set only for sNaN. Go to OUT.
    - Sign=1 and operand is not ±0 (includes -inf): result `CANON_NAN`, NV. Go to OUT.
    - Operand is ±0: result is the operand unchanged, flags 0. Go to OUT.
    - Operand is +inf: result `32'h7F80_0000`, flags 0. Go to OUT.
    - Otherwise: register `core_significand`, `core_is_exp_odd` and the result exponent. Go to START.
- **Exponent rules:**
  - Unbiased E = e−127 for normals; see Configuration for subnormals.
  - `core_is_exp_odd` = E[0].
  - Result biased exponent = (E >>> 1) + 127, using an arithmetic shift (floor).
- **START:** `core_start`=1 for exactly this cycle. Go to WAIT.
- **WAIT:** hold the core inputs stable. When `core_done`=1, capture `core_sq_root`. Go to ROUND.
- **ROUND:**
  - Field extraction: fraction = root[34:12], guard G = root[11], sticky S = |root[10:0], inexact = G|S.
  - Round-up increment:
    - RNE: G&(S|lsb).
    - RTZ and RDN: 0.
    - RUP: G|S.
    - RMM: G.
    - Codes 101–111: treated as RNE.
  - A fraction carry-out zeroes the fraction and increments the exponent.
  - Sign is 0. NX = inexact.
  - Register the result. Go to OUT.
- **OUT:** `out_valid`=1. `out_result` and `out_fflags` are held stable until `out_ready`=1, then go to IDLE.
- `core_done` in any state other than WAIT is ignored.
- No overlap: a new operand is accepted only after the previous result has been taken.

## Timing
- **Reset values:**
  - State IDLE.
  - `in_ready`=1.
  - `out_valid`=0, `out_result`=0, `out_fflags`=0.
  - `core_start`=0, `core_is_exp_odd`=0, `core_significand`=0.
- **Reset mid-operation:** the block returns to IDLE and any pending result is discarded. The parent drives the core's reset from the same source, so the core aborts too.
- **Special operand latency:** accepted at cycle T, `out_valid` at T+1.
- **Normal operand latency:**
  - Accepted at T; `core_start` at T+1.
  - `core_done` is sampled at cycle D; ROUND is cycle D+1; `out_valid` at D+2.
- `in_ready` and `out_valid` are never high in the same cycle.
- **Zero-wait back-to-back:** with `out_ready` tied high, OUT lasts one cycle and IDLE can accept at the next cycle.

## Configuration
- **`FSQRT_SUBNORMAL_EN` defined:**
  - A subnormal operand (e=0, fraction≠0) is normalized in the IDLE capture cycle.
  - Normalization: shift = leading-zero count of the fraction + 1; significand = fraction << shift; E = −126 − shift.
  - The operand then proceeds to START like a normal operand.
- **`FSQRT_SUBNORMAL_EN` undefined:** a subnormal operand is treated as ±0 of the same sign: result is the signed zero, flags 0, 1-cycle path.

## Test plan
- 0x40800000 (4.0), RNE -> 0x40000000, fflags 0. Also 0x3E800000 (0.25) -> 0x3F000000, which checks the even-negative exponent.
- 0x40000000 (2.0), RNE -> 0x3FB504F3, NX. Same operand with RTZ -> 0x3FB504F3; with RUP -> 0x3FB504F4.
- Specials, each with `out_valid` one cycle after acceptance and `core_start` never asserted:
  - 0xBF800000 -> 0x7FC00000, NV.
  - 0x7F800001 -> 0x7FC00000, NV.
  - 0x7FC00000 -> 0x7FC00000, flags 0.
  - 0x80000000 -> 0x80000000.
  - 0x7F800000 -> 0x7F800000.
- 0x00000001 with macro defined -> 0x1A3504F3, NX, `core_is_exp_odd`=1. Without the macro -> 0x00000000, flags 0.
- Back-pressure: hold `out_ready`=0 for 10 cycles after `out_valid`. Result and flags stay stable, `in_ready`=0, and an extra `core_done` pulse has no effect.
- Assert `reset` for one cycle while in WAIT. All outputs return to their reset values, and a following 4.0 operand completes correctly.

Source files
------------

// File: rtl/fsqrt_seq.sv
// fsqrt_seq -- FSQRT.S sequencer between the FPU operand bus and the
// iterative 24-bit square-root core.
//
// Classifies a binary32 radicand. NaN, negative, zero and +inf operands are
// resolved locally in one cycle. Everything else is unpacked into a normalized
// significand plus exponent parity and handed to the core. The 36-bit root
// that comes back is rounded per rm and packed with fflags.
//
// Build option: define FSQRT_SUBNORMAL_EN to normalize subnormal operands and
// take their roots. When it is not defined, subnormals are flushed to a signed
// zero with no flags raised.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only when idle)
//   in_operand, in_rm   binary32 radicand, resolved rounding mode
//   out_valid/out_ready result handshake
//   out_result          binary32 root
//   out_fflags          {NV, DZ, OF, UF, NX}
//   core_start          one-cycle start pulse to the root core
//   core_is_exp_odd     unbiased exponent is odd
//   core_significand    {1, fraction}, normalized
//   core_done           core root valid this cycle
//   core_sq_root        core root, bit 35 is the leading one
//
// state | meaning
// IDLE  | ready for an operand; classify and capture on in_valid
// START | pulse core_start
// WAIT  | core running; core inputs held; capture root on core_done
// ROUND | round and pack the root
// OUT   | result presented until out_ready
module fsqrt_seq #(
    parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_operand,
    input  logic [2:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_fflags,
    output logic        core_start,
    output logic        core_is_exp_odd,
    output logic [23:0] core_significand,
    input  logic        core_done,
    input  logic [35:0] core_sq_root
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_ROUND, S_OUT} state_t;

    state_t      state, state_nxt;

    logic [2:0]  rm_q;
    logic [7:0]  exp_q;
    logic [34:0] root_q;
    logic [31:0] res_q;
    logic [4:0]  flags_q;
    logic [23:0] sig_q;
    logic        odd_q;

    // The core always returns a leading one, so only the bits below it matter.
    logic        unused_root_msb;
    assign unused_root_msb = core_sq_root[35];

    logic        op_sign;
    logic [7:0]  op_exp;
    logic [22:0] op_frac;
    assign op_sign = in_operand[31];
    assign op_exp  = in_operand[30:23];
    assign op_frac = in_operand[22:0];

    logic        is_nan, is_inf, is_zero, is_special;
    logic [31:0] spec_res;
    logic [4:0]  spec_flags;

    always_comb begin
        is_nan = (op_exp == 8'hFF) && (op_frac != '0);
        is_inf = (op_exp == 8'hFF) && (op_frac == '0);
`ifdef FSQRT_SUBNORMAL_EN
        is_zero = (op_exp == '0) && (op_frac == '0);
`else
        // Subnormals are flushed: they take the signed-zero path.
        is_zero = (op_exp == '0);
`endif
        is_special = is_nan | is_inf | is_zero | op_sign;
        spec_res   = CANON_NAN;
        spec_flags = '0;
        if (is_nan) begin
            spec_flags[4] = ~op_frac[22];
        end else if (op_sign && !is_zero) begin
            spec_flags[4] = 1'b1;
        end else if (is_zero) begin
            spec_res = {op_sign, 31'b0};
        end else if (is_inf) begin
            spec_res = 32'h7F80_0000;
        end
    end

    logic        [23:0] norm_sig;
    logic signed [9:0]  norm_exp;
    logic        [7:0]  norm_res_exp;

`ifdef FSQRT_SUBNORMAL_EN
    function automatic logic [4:0] lzc23(input logic [22:0] f);
        lzc23 = 5'd23;
        for (int i = 0; i < 23; i++) begin
            if (f[i]) lzc23 = 5'(22 - i);
        end
    endfunction

    logic [4:0] sub_shift;

    always_comb begin
        sub_shift = lzc23(op_frac) + 5'd1;
        if (op_exp == '0) begin
            norm_sig = {1'b0, op_frac} << sub_shift;
            norm_exp = -10'sd126 - $signed({5'b0, sub_shift});
        end else begin
            norm_sig = {1'b1, op_frac};
            norm_exp = $signed({2'b00, op_exp}) - 10'sd127;
        end
    end
`else
    always_comb begin
        norm_sig = {1'b1, op_frac};
        norm_exp = $signed({2'b00, op_exp}) - 10'sd127;
    end
`endif

    // Floor halving of the unbiased exponent, then rebias.
    assign norm_res_exp = 8'((norm_exp >>> 1) + 10'sd127);

    logic        g_bit, s_bit, round_up;
    logic [23:0] frac_sum;
    logic [31:0] round_res;

    always_comb begin
        g_bit    = root_q[11];
        s_bit    = |root_q[10:0];
        round_up = 1'b0;
        case (rm_q)
            3'b001, 3'b010: round_up = 1'b0;
            3'b011:         round_up = g_bit | s_bit;
            3'b100:         round_up = g_bit;
            default:        round_up = g_bit & (s_bit | root_q[12]);
        endcase
        // A carry out of the fraction leaves it all-zero and bumps the exponent.
        frac_sum  = {1'b0, root_q[34:12]} + {23'b0, round_up};
        round_res = {1'b0, exp_q + {7'b0, frac_sum[23]}, frac_sum[22:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        core_start = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = is_special ? S_OUT : S_START;
            end
            S_START: begin
                core_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT:  if (core_done) state_nxt = S_ROUND;
            S_ROUND: state_nxt = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rm_q    <= '0;
            exp_q   <= '0;
            root_q  <= '0;
            res_q   <= '0;
            flags_q <= '0;
            sig_q   <= '0;
            odd_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    rm_q <= in_rm;
                    if (is_special) begin
                        res_q   <= spec_res;
                        flags_q <= spec_flags;
                    end else begin
                        sig_q <= norm_sig;
                        odd_q <= norm_exp[0];
                        exp_q <= norm_res_exp;
                    end
                end
                S_WAIT:  if (core_done) root_q <= core_sq_root[34:0];
                S_ROUND: begin
                    res_q   <= round_res;
                    flags_q <= {4'b0, g_bit | s_bit};
                end
                default: ;
            endcase
        end
    end

    assign out_result       = res_q;
    assign out_fflags       = flags_q;
    assign core_is_exp_odd  = odd_q;
    assign core_significand = sig_q;

endmodule

// File: tb/tb_fsqrt_seq.sv
module tb_fsqrt_seq;

    localparam logic [31:0] CANON = 32'h7FC0_0000;
`ifdef FSQRT_SUBNORMAL_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_operand;
    logic [2:0]  in_rm;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_fflags;
    logic        core_start, core_is_exp_odd;
    logic [23:0] core_significand;
    logic        core_done;
    logic [35:0] core_sq_root;

    fsqrt_seq #(.CANON_NAN(CANON)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_operand(in_operand), .in_rm(in_rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_fflags(out_fflags),
        .core_start(core_start), .core_is_exp_odd(core_is_exp_odd),
        .core_significand(core_significand),
        .core_done(core_done), .core_sq_root(core_sq_root)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  fl;
        logic        special;
        logic [23:0] sig;
        logic        odd;
    } exp_t;

    function automatic logic [35:0] isqrt(input logic [72:0] x);
        logic [35:0] q = '0;
        logic [72:0] t;
        for (int b = 35; b >= 0; b--) begin
            t = 73'(q | (36'd1 << b));
            if (t * t <= x) q = q | (36'd1 << b);
        end
        return q;
    endfunction

    // Reference: exact floor root of the real value, then arithmetic rounding.
    function automatic exp_t model(input logic [31:0] op, input logic [2:0] rm);
        exp_t        e;
        logic        sgn;
        logic [7:0]  ef;
        logic [22:0] ff;
        bit          zero_like, up;
        int          unb, trunc, rem, bexp;
        logic [23:0] m;
        logic [72:0] x;
        logic [35:0] root;
        e   = '0;
        sgn = op[31];
        ef  = op[30:23];
        ff  = op[22:0];
        zero_like = (ef == 0) && (ff == 0 || !SUB_EN);
        e.special = 1'b1;
        if (ef == 8'hFF && ff != 0) begin
            e.res = CANON;
            e.fl  = ff[22] ? 5'd0 : 5'b10000;
        end else if (sgn && !zero_like) begin
            e.res = CANON;
            e.fl  = 5'b10000;
        end else if (zero_like) begin
            e.res = {sgn, 31'b0};
        end else if (ef == 8'hFF) begin
            e.res = 32'h7F80_0000;
        end else begin
            e.special = 1'b0;
            if (ef == 0) begin
                m   = {1'b0, ff};
                unb = -126;
                while (!m[23]) begin
                    m = m << 1;
                    unb--;
                end
            end else begin
                m   = {1'b1, ff};
                unb = int'(ef) - 127;
            end
            e.sig = m;
            e.odd = (unb % 2 != 0);
            x     = 73'(m) << (47 + (e.odd ? 1 : 0));
            root  = isqrt(x);
            trunc = int'(root[35:12]);
            rem   = int'(root[11:0]);
            case (rm)
                3'd1, 3'd2: up = 0;
                3'd3:       up = (rem != 0);
                3'd4:       up = (rem >= 2048);
                default:    up = (rem > 2048) || (rem == 2048 && (trunc % 2) == 1);
            endcase
            bexp  = (unb - (e.odd ? 1 : 0)) / 2 + 127;
            e.res = 32'(bexp * (1 << 23) + (trunc - (1 << 23)) + (up ? 1 : 0));
            e.fl  = {4'b0, rem != 0};
        end
        return e;
    endfunction

    // ---------------- scoreboard: one transaction in flight ----------------
    exp_t pend;
    logic pend_valid = 1'b0;
    int   pend_acc   = -10;
    int   done_cyc   = -10;
    int   seen_acc   = -100;

    always @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) pend_valid <= 1'b0;
            if (in_valid && in_ready) begin
                pend       <= model(in_operand, in_rm);
                pend_valid <= 1'b1;
                pend_acc   <= cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                check("in_ready_during_out", in_ready, 0);
                if (!pend_valid) begin
                    check("unexpected_out_valid", 0, 1);
                end else begin
                    check("out_result", out_result, pend.res);
                    check("out_fflags", out_fflags, pend.fl);
                    if (seen_acc != pend_acc) begin
                        seen_acc <= pend_acc;
                        if (pend.special) check("special_latency", cyc, pend_acc + 1);
                        else              check("normal_latency", cyc, done_cyc + 2);
                    end
                end
            end
            if (core_start) begin
                check("core_start_legal", pend_valid && !pend.special, 1);
                check("core_start_timing", cyc, pend_acc + 1);
                check("core_significand", core_significand, pend.sig);
                check("core_is_exp_odd", core_is_exp_odd, pend.odd);
            end
        end
    end

    // ---------------- core emulator ----------------
    int          force_lat = -1;
    int          spur_mode = 0;   // 0 none, 1 random, 2 every idle cycle
    bit          busy = 0;
    int          lat = 0;
    logic [35:0] root_r;
    logic [63:0] junk;

    initial begin
        core_done    = 1'b0;
        core_sq_root = '0;
        forever begin
            @(posedge clk);
            #2;
            core_done = 1'b0;
            if (reset) begin
                busy = 0;
            end else if (busy) begin
                if (lat == 0) begin
                    core_done    = 1'b1;
                    core_sq_root = root_r;
                    done_cyc     = cyc;
                    busy         = 0;
                end else begin
                    lat--;
                end
            end else if (core_start) begin
                busy   = 1;
                lat    = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 5));
                root_r = isqrt(73'(core_significand) << (47 + (core_is_exp_odd ? 1 : 0)));
            end else if (spur_mode == 2 || (spur_mode == 1 && $urandom_range(0, 7) == 0)) begin
                junk         = {$urandom, $urandom};
                core_done    = 1'b1;
                core_sq_root = junk[35:0];
            end
        end
    end

    // ---------------- out_ready driver ----------------
    int rdy_mode = 1;   // 0 random, 1 tied high, 2 held low
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            out_ready = (rdy_mode == 1) ? 1'b1 :
                        (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] op, input logic [2:0] rm, output int acc);
        int n = 0;
        in_valid   = 1'b1;
        in_operand = op;
        in_rm      = rm;
        do begin
            @(posedge clk);
            n++;
        end while (!in_ready && n < 500);
        #1;
        in_valid = 1'b0;
        acc = cyc - 1;
        if (n >= 500) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (pend_valid && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 2000) check("completion_timeout", 0, 1);
    endtask

    task automatic run(input logic [31:0] op, input logic [2:0] rm);
        int acc;
        send(op, rm, acc);
        wait_done();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_result"}, out_result, 0);
        check({tag, "_out_fflags"}, out_fflags, 0);
        check({tag, "_core_start"}, core_start, 0);
        check({tag, "_core_odd"}, core_is_exp_odd, 0);
        check({tag, "_core_sig"}, core_significand, 0);
    endtask

    task automatic pin(input string name, input logic [31:0] op, input logic [2:0] rm,
                       input logic [31:0] res, input logic [4:0] fl);
        exp_t e;
        e = model(op, rm);
        check({"model_", name}, {e.res, e.fl}, {res, fl});
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3, n;
        logic [31:0] op;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_operand = '0;
        in_rm      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // hand-computed values that pin the model
        pin("4p0_rne",  32'h4080_0000, 3'd0, 32'h4000_0000, 5'd0);
        pin("0p25_rne", 32'h3E80_0000, 3'd0, 32'h3F00_0000, 5'd0);
        pin("2p0_rne",  32'h4000_0000, 3'd0, 32'h3FB5_04F3, 5'd1);
        pin("2p0_rtz",  32'h4000_0000, 3'd1, 32'h3FB5_04F3, 5'd1);
        pin("2p0_rup",  32'h4000_0000, 3'd3, 32'h3FB5_04F4, 5'd1);
        pin("neg_one",  32'hBF80_0000, 3'd0, 32'h7FC0_0000, 5'b10000);
        pin("snan",     32'h7F80_0001, 3'd0, 32'h7FC0_0000, 5'b10000);
        pin("qnan",     32'h7FC0_0000, 3'd0, 32'h7FC0_0000, 5'd0);
        pin("neg_zero", 32'h8000_0000, 3'd0, 32'h8000_0000, 5'd0);
        pin("pos_inf",  32'h7F80_0000, 3'd0, 32'h7F80_0000, 5'd0);
`ifdef FSQRT_SUBNORMAL_EN
        pin("min_sub",  32'h0000_0001, 3'd0, 32'h1A35_04F3, 5'd1);
`else
        pin("min_sub",  32'h0000_0001, 3'd0, 32'h0000_0000, 5'd0);
`endif

        // directed cases through the DUT
        rdy_mode = 1;
        run(32'h4080_0000, 3'd0);
        run(32'h3E80_0000, 3'd0);
        run(32'h4000_0000, 3'd0);
        run(32'h4000_0000, 3'd1);
        run(32'h4000_0000, 3'd3);
        run(32'hBF80_0000, 3'd0);
        run(32'h7F80_0001, 3'd0);
        run(32'h7FC0_0000, 3'd0);
        run(32'h8000_0000, 3'd0);
        run(32'h7F80_0000, 3'd0);
        run(32'h0000_0001, 3'd0);
        run(32'h0000_0001, 3'd4);
        run(32'h3F80_0000, 3'd2);

        // zero-wait back-to-back with out_ready tied high
        send(32'h7F80_0000, 3'd0, a1);
        send(32'h8000_0000, 3'd0, a2);
        send(32'h4080_0000, 3'd0, a3);
        check("b2b_accept_gap", a2, a1 + 2);
        wait_done();

        // back-pressure with stray core_done pulses
        rdy_mode  = 2;
        send(32'h4000_0000, 3'd3, a1);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_seen", out_valid, 1);
        spur_mode = 2;
        repeat (10) @(negedge clk);
        check("bp_result_held", out_result, 32'h3FB5_04F4);
        check("bp_in_ready_low", in_ready, 0);
        spur_mode = 0;
        @(posedge clk);
        #1 rdy_mode = 1;
        wait_done();

        // reset while the core is busy
        force_lat = 30;
        send(32'h4000_0000, 3'd0, a1);
        n = 0;
        while (!core_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_core_start_seen", core_start, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        force_lat = -1;
        @(posedge clk);
        #1;
        run(32'h4080_0000, 3'd0);

        // randomized traffic
        rdy_mode  = 0;
        spur_mode = 1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
                4:          op = {1'b0, ($urandom_range(0, 1) != 0) ? 8'd1 : 8'd254, 23'($urandom)};
                5:          op = {1'($urandom), 8'd0, 23'($urandom_range(1, 32'h7F_FFFF) >> $urandom_range(0, 22))};
                6:          op = {1'b1, 8'($urandom_range(1, 255)), 23'($urandom)};
                7:          op = {1'($urandom), 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
                8:          op = {1'($urandom), ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00, 23'd0};
                default:    op = $urandom;
            endcase
            send(op, 3'($urandom_range(0, 7)), a1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        wait_done();
        spur_mode = 0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
